fu_ctrl: RTL

FU_CTRL -- requirements
Module: fu_ctrl

---
 rtl/mycpu_pkg.sv | 42 ++++
 rtl/fu.sv | 43 ++++
 rtl/fu_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mycpu_pkg.sv
// ============================================================================
// Module      : mycpu_pkg
// Description : Shared types for the function-unit controller.
//               The MUL state exists only when FU_CTRL_MUL_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mycpu_pkg;

    localparam int c_DW = 16;

    typedef enum logic [3:0] {
        FADD  = 4'h0,
        FSUB  = 4'h1,
        FAND  = 4'h2,
        FOR   = 4'h3,
        FXOR  = 4'h4,
        FNOT  = 4'h5,
        FPASS = 4'h6,
        FSHL  = 4'h7,
        FSHR  = 4'h8,
        FMUL  = 4'h9
    } fs_t;

`ifdef FU_CTRL_MUL_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        WB   = 2'd3
    } ctrl_state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1
    } ctrl_state_t;
`endif

endpackage

`default_nettype wire

// File: rtl/fu.sv
// ============================================================================
// Module      : fu
// Description : 16-bit combinational function unit with zero/negative flags.
//               FMUL and unassigned codes are reported as illegal.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fu
    import mycpu_pkg::*;
(
    input  fs_t               fs,
    input  logic [c_DW-1:0]   a,
    input  logic [c_DW-1:0]   b,
    output logic [c_DW-1:0]   f_out,
    output logic              z_out,
    output logic              n_out,
    output logic              illegal
);

    always_comb begin
        f_out   = '0;
        illegal = 1'b0;
        case (fs)
            FADD:    f_out = a + b;
            FSUB:    f_out = a - b;
            FAND:    f_out = a & b;
            FOR:     f_out = a | b;
            FXOR:    f_out = a ^ b;
            FNOT:    f_out = ~a;
            FPASS:   f_out = a;
            FSHL:    f_out = a << 1;
            FSHR:    f_out = a >> 1;
            default: illegal = 1'b1;
        endcase
    end

    assign z_out = (f_out == '0);
    assign n_out = f_out[c_DW-1];

endmodule

`default_nettype wire

// File: rtl/fu_ctrl.sv
// ============================================================================
// Module      : fu_ctrl
// Description : Register file plus sequencing controller around one shared fu.
//               Define FU_CTRL_MUL_EN to enable shift-add FMUL.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fu_ctrl
    import mycpu_pkg::*;
#(
    parameter int NREG = 8,
    parameter int AW   = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_fs,
    input  logic [AW-1:0]     cmd_dst,
    input  logic [AW-1:0]     cmd_a,
    input  logic [AW-1:0]     cmd_b,
    output logic              done,
    output logic              err,
    output logic              z_flag,
    output logic              n_flag,
    output logic              busy,
    input  logic              dbg_we,
    input  logic [AW-1:0]     dbg_addr,
    input  logic [c_DW-1:0]   dbg_wdata,
    output logic [c_DW-1:0]   dbg_rdata
);

    ctrl_state_t       r_state;
    ctrl_state_t       w_state_nxt;
    fs_t               r_fs;
    logic [AW-1:0]     r_dst;
    logic [c_DW-1:0]   r_opa;
    logic [c_DW-1:0]   r_opb;
    logic [c_DW-1:0]   r_regs [NREG];

    fs_t               w_fu_fs;
    logic [c_DW-1:0]   w_fu_a;
    logic [c_DW-1:0]   w_fu_b;
    logic [c_DW-1:0]   w_fu_f;
    logic              w_fu_z;
    logic              w_fu_n;
    logic              w_fu_ill;

    logic              w_accept;
    logic              w_wb_en;
    logic [c_DW-1:0]   w_wb_data;
    logic              w_wb_z;
    logic              w_wb_n;
    logic              w_done_nxt;
    logic              w_err_nxt;

`ifdef FU_CTRL_MUL_EN
    logic [c_DW-1:0]   r_acc;
    logic [c_DW-1:0]   r_mc;
    logic [c_DW-1:0]   r_mp;
    logic [3:0]        r_cnt;
`endif

    assign cmd_ready = (r_state == IDLE);
    assign busy      = ~cmd_ready;
    assign w_accept  = cmd_valid & cmd_ready;
    assign dbg_rdata = r_regs[dbg_addr];

    fu u_fu (
        .fs      (w_fu_fs),
        .a       (w_fu_a),
        .b       (w_fu_b),
        .f_out   (w_fu_f),
        .z_out   (w_fu_z),
        .n_out   (w_fu_n),
        .illegal (w_fu_ill)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fu_fs     = r_fs;
        w_fu_a      = r_opa;
        w_fu_b      = r_opb;
        w_wb_en     = 1'b0;
        w_wb_data   = w_fu_f;
        w_wb_z      = w_fu_z;
        w_wb_n      = w_fu_n;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (cmd_valid) begin
`ifdef FU_CTRL_MUL_EN
                    if (fs_t'(cmd_fs) == FMUL) w_state_nxt = MUL;
                    else                       w_state_nxt = EXEC;
`else
                    w_state_nxt = EXEC;
`endif
                end
            end
            EXEC: begin
                w_state_nxt = IDLE;
                w_done_nxt  = 1'b1;
                w_err_nxt   = w_fu_ill;
                w_wb_en     = ~w_fu_ill;
            end
`ifdef FU_CTRL_MUL_EN
            // The adder is borrowed for the accumulate step of each MUL cycle
            MUL: begin
                w_fu_fs = FADD;
                w_fu_a  = r_acc;
                w_fu_b  = r_mc;
                if (r_cnt == 4'd15) w_state_nxt = WB;
            end
            WB: begin
                w_state_nxt = IDLE;
                w_done_nxt  = 1'b1;
                w_wb_en     = 1'b1;
                w_wb_data   = r_acc;
                w_wb_z      = (r_acc == '0);
                w_wb_n      = r_acc[c_DW-1];
            end
`endif
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fs   <= FADD;
            r_dst  <= '0;
            r_opa  <= '0;
            r_opb  <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
            z_flag <= 1'b0;
            n_flag <= 1'b0;
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else begin
            if (w_accept) begin
                r_fs  <= fs_t'(cmd_fs);
                r_dst <= cmd_dst;
                r_opa <= r_regs[cmd_a];
                r_opb <= r_regs[cmd_b];
            end
            done <= w_done_nxt;
            err  <= w_err_nxt;
            if (dbg_we) r_regs[dbg_addr] <= dbg_wdata;
            // Later assignment gives the writeback priority on an address clash
            if (w_wb_en) begin
                r_regs[r_dst] <= w_wb_data;
                z_flag        <= w_wb_z;
                n_flag        <= w_wb_n;
            end
        end
    end

`ifdef FU_CTRL_MUL_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_mc  <= '0;
            r_mp  <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_acc <= '0;
            r_mc  <= r_regs[cmd_a];
            r_mp  <= r_regs[cmd_b];
            r_cnt <= '0;
        end else if (r_state == MUL) begin
            if (r_mp[0]) r_acc <= w_fu_f;
            r_mc  <= r_mc << 1;
            r_mp  <= r_mp >> 1;
            r_cnt <= r_cnt + 4'd1;
        end
    end
`endif

endmodule

`default_nettype wire
